// File: rtl/ex_stage.sv
// Execute stage of a 5-stage RV32I pipeline: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register. Redirect outputs are combinational.
module ex_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        StallM,
    input  logic [1:0]  ALUOp_decode,
    input  logic        RegWrite_decode,
    input  logic        ALUSrc_decode,
    input  logic        MemRead_decode,
    input  logic        MemWrite_decode,
    input  logic        MemtoReg_decode,
    input  logic        branch_decode,
    input  logic        lui_decode,
    input  logic        jump_decode,
    input  logic        jalr_decode,
    input  logic [31:0] pc_decode,
    input  logic [31:0] data1_decode,
    input  logic [31:0] data2_decode,
    input  logic [31:0] imm_out_decode,
    input  logic [2:0]  funct3_decode,
    input  logic [6:0]  funct7_decode,
    input  logic [4:0]  rd_decode,
    input  logic [1:0]  ForwardAE,
    input  logic [1:0]  ForwardBE,
    input  logic [31:0] alu_result_mem,
    input  logic [31:0] result_wb,
    output logic        PCSrcE,
    output logic [31:0] pc_target,
    output logic [31:0] alu_result_execute,
    output logic [31:0] write_data_execute,
    output logic [31:0] pc_plus4_execute,
    output logic [4:0]  rd_execute,
    output logic [2:0]  funct3_execute,
    output logic        RegWrite_execute,
    output logic        MemRead_execute,
    output logic        MemWrite_execute,
    output logic        MemtoReg_execute
);

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND
    } alu_op_t;

    alu_op_t     alu_op;
    logic [31:0] src_a;
    logic [31:0] fwd_b;
    logic [31:0] src_b;
    logic [31:0] alu_out;
    logic [31:0] exec_result;
    logic [31:0] pc_plus4;
    logic [31:0] jalr_sum;
    logic [4:0]  shamt;
    logic        branch_cond;

    // Only funct7[5] selects an alternate operation in RV32I.
    logic unused_funct7;
    assign unused_funct7 = ^{funct7_decode[6], funct7_decode[4:0]};

    always_comb begin
        case (ForwardAE)
            2'b01:   src_a = result_wb;
            2'b10:   src_a = alu_result_mem;
            default: src_a = data1_decode;
        endcase
    end

    always_comb begin
        case (ForwardBE)
            2'b01:   fwd_b = result_wb;
            2'b10:   fwd_b = alu_result_mem;
            default: fwd_b = data2_decode;
        endcase
    end

    assign src_b = ALUSrc_decode ? imm_out_decode : fwd_b;
    assign shamt = src_b[4:0];

    always_comb begin
        alu_op = ALU_ADD;
        case (ALUOp_decode)
            2'b00: alu_op = ALU_ADD;
            2'b01: alu_op = ALU_SUB;
            default: begin
                case (funct3_decode)
                    // ADDI has no SUB form, so funct7 is ignored for I-type 000.
                    3'b000:  alu_op = (ALUOp_decode == 2'b10 && funct7_decode[5]) ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_op = ALU_SLL;
                    3'b010:  alu_op = ALU_SLT;
                    3'b011:  alu_op = ALU_SLTU;
                    3'b100:  alu_op = ALU_XOR;
                    3'b101:  alu_op = funct7_decode[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_op = ALU_OR;
                    default: alu_op = ALU_AND;
                endcase
            end
        endcase
    end

    always_comb begin
        alu_out = '0;
        case (alu_op)
            ALU_ADD:  alu_out = src_a + src_b;
            ALU_SUB:  alu_out = src_a - src_b;
            ALU_SLL:  alu_out = src_a << shamt;
            ALU_SLT:  alu_out = {31'd0, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_out = {31'd0, src_a < src_b};
            ALU_XOR:  alu_out = src_a ^ src_b;
            ALU_SRL:  alu_out = src_a >> shamt;
            ALU_SRA:  alu_out = $unsigned($signed(src_a) >>> shamt);
            ALU_OR:   alu_out = src_a | src_b;
            ALU_AND:  alu_out = src_a & src_b;
            default:  alu_out = '0;
        endcase
    end

    assign pc_plus4 = pc_decode + 32'd4;

    always_comb begin
        if (lui_decode)
            exec_result = imm_out_decode;
        else if (jump_decode || jalr_decode)
            exec_result = pc_plus4;
        else
            exec_result = alu_out;
    end

    always_comb begin
        case (funct3_decode)
            3'b000:  branch_cond = (src_a == fwd_b);
            3'b001:  branch_cond = (src_a != fwd_b);
            3'b100:  branch_cond = ($signed(src_a) < $signed(fwd_b));
            3'b101:  branch_cond = !($signed(src_a) < $signed(fwd_b));
            3'b110:  branch_cond = (src_a < fwd_b);
            3'b111:  branch_cond = !(src_a < fwd_b);
            default: branch_cond = 1'b0;
        endcase
    end

    assign PCSrcE    = (branch_decode && branch_cond) || jump_decode || jalr_decode;
    assign jalr_sum  = src_a + imm_out_decode;
    assign pc_target = jalr_decode ? {jalr_sum[31:1], 1'b0} : (pc_decode + imm_out_decode);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alu_result_execute <= '0;
            write_data_execute <= '0;
            pc_plus4_execute   <= '0;
            rd_execute         <= '0;
            funct3_execute     <= '0;
            RegWrite_execute   <= 1'b0;
            MemRead_execute    <= 1'b0;
            MemWrite_execute   <= 1'b0;
            MemtoReg_execute   <= 1'b0;
        end else if (!StallM) begin
            alu_result_execute <= exec_result;
            write_data_execute <= fwd_b;
            pc_plus4_execute   <= pc_plus4;
            rd_execute         <= rd_decode;
            funct3_execute     <= funct3_decode;
            RegWrite_execute   <= RegWrite_decode;
            MemRead_execute    <= MemRead_decode;
            MemWrite_execute   <= MemWrite_decode;
            MemtoReg_execute   <= MemtoReg_decode;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Scoreboard bench for ex_stage: random and directed ID/EX stimulus checked against
// an arithmetic reference model; comb and registered outputs are monitored separately.
module tb_ex_stage;

    typedef struct packed {
        logic [1:0]  aluop;
        logic        rw, alusrc, mr, mw, m2r, br, lui, jmp, jalr;
        logic [31:0] pc, d1, d2, imm;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic [1:0]  fa, fb;
        logic [31:0] mem, wb;
    } in_t;

    typedef struct packed {
        logic [31:0] alu, wd, pc4;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic        rw, mr, mw, m2r;
    } regs_t;

    typedef struct packed {
        logic        take;
        logic [31:0] tgt;
    } comb_t;

    logic clk = 1'b0;
    logic rst;
    logic StallM;
    in_t  cur;

    logic        PCSrcE;
    logic [31:0] pc_target, alu_result_execute, write_data_execute, pc_plus4_execute;
    logic [4:0]  rd_execute;
    logic [2:0]  funct3_execute;
    logic        RegWrite_execute, MemRead_execute, MemWrite_execute, MemtoReg_execute;

    always #5 clk = ~clk;

    ex_stage dut (
        .clk(clk), .rst(rst), .StallM(StallM),
        .ALUOp_decode(cur.aluop), .RegWrite_decode(cur.rw), .ALUSrc_decode(cur.alusrc),
        .MemRead_decode(cur.mr), .MemWrite_decode(cur.mw), .MemtoReg_decode(cur.m2r),
        .branch_decode(cur.br), .lui_decode(cur.lui), .jump_decode(cur.jmp), .jalr_decode(cur.jalr),
        .pc_decode(cur.pc), .data1_decode(cur.d1), .data2_decode(cur.d2), .imm_out_decode(cur.imm),
        .funct3_decode(cur.f3), .funct7_decode(cur.f7), .rd_decode(cur.rd),
        .ForwardAE(cur.fa), .ForwardBE(cur.fb), .alu_result_mem(cur.mem), .result_wb(cur.wb),
        .PCSrcE(PCSrcE), .pc_target(pc_target),
        .alu_result_execute(alu_result_execute), .write_data_execute(write_data_execute),
        .pc_plus4_execute(pc_plus4_execute), .rd_execute(rd_execute), .funct3_execute(funct3_execute),
        .RegWrite_execute(RegWrite_execute), .MemRead_execute(MemRead_execute),
        .MemWrite_execute(MemWrite_execute), .MemtoReg_execute(MemtoReg_execute)
    );

    int    vectors = 0;
    int    miscompares = 0;
    regs_t reg_q[$];
    comb_t comb_q[$];
    regs_t mstate;
    bit    mon_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] opa(input in_t x);
        if (x.fa == 2'b01) return x.wb;
        if (x.fa == 2'b10) return x.mem;
        return x.d1;
    endfunction

    function automatic logic [31:0] opb(input in_t x);
        if (x.fb == 2'b01) return x.wb;
        if (x.fb == 2'b10) return x.mem;
        return x.d2;
    endfunction

    function automatic logic [31:0] ref_alu(input in_t x);
        logic [31:0] a, b, r, ones;
        int sh;
        a    = opa(x);
        b    = x.alusrc ? x.imm : opb(x);
        sh   = int'(b[4:0]);
        ones = '1;
        if (x.aluop == 2'b00) return a + b;
        if (x.aluop == 2'b01) return a - b;
        case (x.f3)
            3'd0: return (x.aluop == 2'b10 && x.f7[5]) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: begin
                r = a >> sh;
                if (x.f7[5] && a[31]) r = r | ~(ones >> sh);
                return r;
            end
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic comb_t ref_comb(input in_t x);
        comb_t c;
        logic [31:0] a, b;
        logic cond;
        a = opa(x);
        b = opb(x);
        case (x.f3)
            3'd0: cond = (a == b);
            3'd1: cond = (a != b);
            3'd4: cond = $signed(a) < $signed(b);
            3'd5: cond = $signed(a) >= $signed(b);
            3'd6: cond = a < b;
            3'd7: cond = a >= b;
            default: cond = 1'b0;
        endcase
        c.take = (x.br && cond) || x.jmp || x.jalr;
        c.tgt  = x.jalr ? ((a + x.imm) & 32'hFFFF_FFFE) : (x.pc + x.imm);
        return c;
    endfunction

    function automatic regs_t capture(input in_t x);
        regs_t r;
        if (x.lui)                r.alu = x.imm;
        else if (x.jmp || x.jalr) r.alu = x.pc + 4;
        else                      r.alu = ref_alu(x);
        r.wd  = opb(x);
        r.pc4 = x.pc + 4;
        r.rd  = x.rd;
        r.f3  = x.f3;
        r.rw  = x.rw;
        r.mr  = x.mr;
        r.mw  = x.mw;
        r.m2r = x.m2r;
        return r;
    endfunction

    function automatic in_t rand_in();
        in_t x;
        x = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        case ($urandom_range(0, 3))
            0: x.f7 = 7'b0100000;
            1: x.f7 = 7'b0000000;
            default: ;
        endcase
        if ($urandom_range(0, 2) != 0) begin
            x.lui  = 1'b0;
            x.jmp  = 1'b0;
            x.jalr = 1'b0;
        end
        if ($urandom_range(0, 7) == 0) begin
            x.rw = 0; x.alusrc = 0; x.mr = 0; x.mw = 0; x.m2r = 0;
            x.br = 0; x.lui = 0; x.jmp = 0; x.jalr = 0; x.aluop = 0;
        end
        if ($urandom_range(0, 3) == 0) x.d2 = x.d1;
        return x;
    endfunction

    // Drive one ID/EX word just after a rising edge and queue what it should produce.
    task automatic apply(input in_t x, input logic stall);
        @(posedge clk);
        #1;
        cur    = x;
        StallM = stall;
        comb_q.push_back(ref_comb(x));
        if (!stall) mstate = capture(x);
        reg_q.push_back(mstate);
    endtask

    task automatic check_regs_zero(input string tag);
        check32({tag, "_alu"}, alu_result_execute, 32'd0);
        check32({tag, "_wd"}, write_data_execute, 32'd0);
        check32({tag, "_pc4"}, pc_plus4_execute, 32'd0);
        check32({tag, "_rdf3"}, {24'd0, rd_execute, funct3_execute}, 32'd0);
        check32({tag, "_ctl"}, {28'd0, RegWrite_execute, MemRead_execute, MemWrite_execute, MemtoReg_execute}, 32'd0);
    endtask

    // ---------------- monitors ----------------
    initial begin
        comb_t e;
        forever begin
            @(negedge clk);
            if (comb_q.size() > 0) begin
                e = comb_q.pop_front();
                check32("PCSrcE", {31'd0, PCSrcE}, {31'd0, e.take});
                check32("pc_target", pc_target, e.tgt);
            end
        end
    end

    initial begin
        regs_t e;
        forever begin
            @(posedge clk);
            if (mon_en && reg_q.size() > 0) begin
                e = reg_q.pop_front();
                @(negedge clk);
                check32("alu_result_execute", alu_result_execute, e.alu);
                check32("write_data_execute", write_data_execute, e.wd);
                check32("pc_plus4_execute", pc_plus4_execute, e.pc4);
                check32("rd_execute", {27'd0, rd_execute}, {27'd0, e.rd});
                check32("funct3_execute", {29'd0, funct3_execute}, {29'd0, e.f3});
                check32("ctl_execute",
                        {28'd0, RegWrite_execute, MemRead_execute, MemWrite_execute, MemtoReg_execute},
                        {28'd0, e.rw, e.mr, e.mw, e.m2r});
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        in_t x;
        rst    = 1'b1;
        StallM = 1'b1;
        cur    = '0;
        mstate = '0;
        #1 rst = 1'b0;
        #1 check_regs_zero("reset");
        #20 rst = 1'b1;
        mon_en = 1'b1;

        // R-type SUB
        x = '0; x.aluop = 2'b10; x.f7 = 7'b0100000; x.d1 = 32'd5; x.d2 = 32'd7; x.rw = 1'b1; x.rd = 5'd3;
        apply(x, 1'b0);
        // SRAI with funct7[5]=1
        x = '0; x.aluop = 2'b11; x.f3 = 3'b101; x.f7 = 7'b0100000; x.d1 = 32'h8000_0000;
        x.imm = 32'd4; x.alusrc = 1'b1; x.rw = 1'b1;
        apply(x, 1'b0);
        check32("sub_result", alu_result_execute, 32'hFFFF_FFFE);
        check32("sub_regwrite", {31'd0, RegWrite_execute}, 32'd1);
        x.f7 = 7'b0000000;
        apply(x, 1'b0);
        check32("srai_result", alu_result_execute, 32'hF800_0000);
        // Forwarded BLT
        x = '0; x.aluop = 2'b01; x.fa = 2'b10; x.mem = 32'hFFFF_FFFD; x.d1 = 32'h55; x.d2 = 32'd2;
        x.br = 1'b1; x.f3 = 3'b100; x.pc = 32'h100; x.imm = 32'hFFFF_FFF8;
        apply(x, 1'b0);
        check32("srli_result", alu_result_execute, 32'h0800_0000);
        #1;
        check32("blt_pcsrc", {31'd0, PCSrcE}, 32'd1);
        check32("blt_target", pc_target, 32'h0000_00F8);
        // JALR
        x = '0; x.jalr = 1'b1; x.rw = 1'b1; x.alusrc = 1'b1; x.d1 = 32'h2001; x.imm = 32'd4;
        x.pc = 32'h40; x.rd = 5'd1;
        apply(x, 1'b0);
        #1;
        check32("jalr_target", pc_target, 32'h0000_2004);
        check32("jalr_pcsrc", {31'd0, PCSrcE}, 32'd1);
        // Bubble
        x = '0; x.d1 = 32'h1234; x.d2 = 32'h1234;
        apply(x, 1'b0);
        check32("jalr_link", alu_result_execute, 32'h0000_0044);
        #1;
        check32("bubble_pcsrc", {31'd0, PCSrcE}, 32'd0);
        apply(rand_in(), 1'b0);
        check32("bubble_ctl", {29'd0, RegWrite_execute, MemRead_execute, MemWrite_execute}, 32'd0);

        // Three stalled cycles with changing inputs, then release.
        apply(rand_in(), 1'b1);
        apply(rand_in(), 1'b1);
        apply(rand_in(), 1'b1);
        apply(rand_in(), 1'b0);
        apply(rand_in(), 1'b0);

        for (int i = 0; i < 400; i++)
            apply(rand_in(), ($urandom_range(0, 3) == 0));

        // Asynchronous reset between edges while stalled on a store.
        x = rand_in(); x.mw = 1'b1;
        apply(x, 1'b0);
        apply(rand_in(), 1'b1);
        @(negedge clk);
        mon_en = 1'b0;
        #2;
        check32("pre_reset_memwrite", {31'd0, MemWrite_execute}, 32'd1);
        rst = 1'b0;
        #1 check_regs_zero("async_reset");
        @(posedge clk);
        #1 StallM = 1'b0;
        @(posedge clk);
        #1 check_regs_zero("reset_hold");
        @(negedge clk);
        StallM = 1'b1;
        rst    = 1'b1;
        mstate = '0;
        reg_q.delete();
        mon_en = 1'b1;
        apply(rand_in(), 1'b0);
        for (int i = 0; i < 40; i++)
            apply(rand_in(), ($urandom_range(0, 3) == 0));

        repeat (3) @(negedge clk);
        vectors++;
        if (reg_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected results never observed, required 0", reg_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 The block SHALL have these ports, in this order:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-low reset.
- StallM  in  1  hold the EX/MEM register; memory-wait request from the hazard unit.
- ALUOp_decode, RegWrite_decode, ALUSrc_decode, MemRead_decode, MemWrite_decode, MemtoReg_decode, branch_decode, lui_decode, jump_decode, jalr_decode  in  2/1 each  control outputs of the ID/EX register.
- pc_decode, data1_decode, data2_decode, imm_out_decode  in  32 each  ID/EX data.
- funct3_decode  in  3  ID/EX data.
- funct7_decode  in  7  ID/EX data.
- rd_decode  in  5  ID/EX data.
- ForwardAE, ForwardBE  in  2 each  operand select: 00 register, 01 result_wb, 10 alu_result_mem, 11 register.
- alu_result_mem, result_wb  in  32 each  forwarded values.
- PCSrcE  out  1  combinational redirect: taken branch, jal or jalr.
- pc_target  out  32  combinational redirect address.
- alu_result_execute, write_data_execute, pc_plus4_execute  out  32 each  registered EX/MEM values.
- rd_execute  out  5  registered.
- funct3_execute  out  3  registered.
- RegWrite_execute, MemRead_execute, MemWrite_execute, MemtoReg_execute  out  1 each  registered.

Function
REQ-002 srcA SHALL be selected from data1_decode by ForwardAE; fwdB SHALL be selected from data2_decode by ForwardBE.
REQ-003 srcB SHALL equal imm_out_decode when ALUSrc_decode=1, else fwdB.
REQ-004 ALU operation SHALL be decoded as follows:
- ALUOp 00: ADD.
- ALUOp 01: SUB.
- ALUOp 10 (R-type), by funct3: 000 ADD, or SUB if funct7[5]=1; 001 SLL; 010 SLT; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7[5]=1; 110 OR; 111 AND.
- ALUOp 11 (I-type): as for 10, except funct3 000 is always ADD; funct7[5] is honoured only for funct3 101.
REQ-005 Shift amount SHALL be srcB[4:0]; SRA SHALL sign-extend; SLT SHALL compare signed and SLTU unsigned, each yielding 32'd0 or 32'd1; ADD and SUB SHALL wrap modulo 2^32.
REQ-006 Execute result SHALL be selected in this order: imm_out_decode when lui_decode=1; else pc_decode+4 when jump_decode or jalr_decode=1; else the ALU output.
REQ-007 Branch condition SHALL compare srcA with fwdB by funct3_decode: 000 eq; 001 ne; 100 signed lt; 101 signed ge; 110 unsigned lt; 111 unsigned ge; any other code not taken.
REQ-008 PCSrcE SHALL equal (branch_decode AND condition) OR jump_decode OR jalr_decode.
REQ-009 pc_target SHALL equal (srcA + imm_out_decode) with bit0 cleared when jalr_decode=1; otherwise pc_decode + imm_out_decode.
REQ-010 On each rising clk with StallM=0, the EX/MEM register SHALL capture:
- alu_result_execute <= execute result.
- write_data_execute <= fwdB.
- pc_plus4_execute <= pc_decode+4.
- rd_execute, funct3_execute and all four control bits <= their _decode inputs.
REQ-011 With StallM=1, every registered output SHALL hold its value.
REQ-012 Latency SHALL be one cycle from ID/EX outputs to EX/MEM outputs; PCSrcE and pc_target SHALL have zero-cycle latency.
REQ-013 A bubble (all _decode controls 0) SHALL produce RegWrite, MemRead and MemWrite _execute = 0 and PCSrcE = 0.
REQ-014 PCSrcE SHALL NOT be gated by StallM; repeating the same redirect while stalled is idempotent.
REQ-015 When rd_decode=0 the block SHALL pass RegWrite unchanged; suppressing x0 writes is the register file's responsibility.

Reset
REQ-016 rst=0 SHALL clear all registered outputs to 0 immediately, independent of clk.
REQ-017 rst=0 SHALL override StallM.
REQ-018 Deassertion of rst SHALL take effect at the first rising clk edge after rst goes high.
REQ-019 A reset asserted mid-stall SHALL discard the held instruction.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- R-type SUB: data1=5, data2=7, funct7=0100000 -> next cycle alu_result_execute=32'hFFFFFFFE, RegWrite_execute=1.
- SRAI: data1=32'h80000000, imm=4, ALUOp=11, funct3=101, funct7[5]=1 -> result 32'hF8000000; same with funct7[5]=0 -> 32'h08000000.
- Forwarding into BLT: ForwardAE=10, alu_result_mem=-3, data2=2, branch=1, funct3=100, pc=32'h100, imm=-8 -> PCSrcE=1, pc_target=32'hF8 in the same cycle.
- JALR: data1=32'h2001, imm=4, pc=32'h40 -> pc_target=32'h2004, PCSrcE=1; next cycle alu_result_execute=32'h44.
- StallM=1 for 3 cycles with changing inputs -> registered outputs stay unchanged; first edge after StallM=0 captures the current inputs.
- rst=0 asynchronously between edges while MemWrite_execute=1 -> all registered outputs read 0 before the next edge.
